fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Program-counter and fetch-redirect unit for the 16-bit processor. It is the consumer of the branch-taken decision made in execute. It holds the fetch address and advances it sequentially. On a taken branch it loads the branch target and squashes wrong-path instructions already in decode/execute for a programmable number of cycles. It also handles fetch stall and halt, and keeps a saturating count of taken branches for debug.

## Interface
- PC_WIDTH, 16, width of the program counter (word-addressed).
- RESET_PC, 16'h0000, PC value loaded on reset.
- FLUSH_DEPTH, 2, number of squash cycles after a redirect; legal range 1..7.

- clk_pi  input  1  clock; all state updates on rising edge.
- reset_pi  input  1  asynchronous, active-high reset.
- stall_pi  input  1  hold the PC (decode backpressure).
- halt_pi  input  1  stop fetch; sticky until reset.
- is_branch_taken_pi  input  1  resolved taken-branch decision from execute.
- branch_target_pi  input  PC_WIDTH  target address, valid when is_branch_taken_pi=1.
- pc_po  output  PC_WIDTH  current fetch address.
- fetch_valid_po  output  1  the instruction fetched at pc_po may enter decode.
- flush_po  output  1  squash all younger instructions in decode/execute.
- halted_po  output  1  unit is in HALTED state.
- branch_count_po  output  16  number of accepted taken branches, saturating.

## Operation
- States: RUN, FLUSH, HALTED. There is a 3-bit flush counter flush_cnt.
- Reset (asynchronous): state=RUN, pc_po=RESET_PC, flush_cnt=0, branch_count_po=0. Outputs during and after reset are fetch_valid_po=1, flush_po=0, halted_po=0.
- Event priority each cycle, highest first: reset, halt_pi, accepted branch, stall_pi, sequential increment.
- RUN:
  - halt_pi=1: go to HALTED; PC holds.
  - is_branch_taken_pi=1 (branch accepted):
    - pc <= branch_target_pi
    - flush_cnt <= FLUSH_DEPTH
    - go to FLUSH
    - branch_count_po increments.
  - A taken branch overrides stall_pi in the same cycle.
  - Otherwise, stall_pi=1: PC holds.
  - Otherwise: pc <= pc+1, modulo 2^PC_WIDTH (16'hFFFF wraps to 16'h0000).
- FLUSH:
  - pc holds at the target.
  - flush_cnt decrements each cycle; return to RUN when flush_cnt reaches 1 and is decremented.
  - is_branch_taken_pi is ignored: it comes from a squashed instruction. It is neither accepted nor counted.
  - stall_pi is ignored.
  - halt_pi=1 goes to HALTED immediately and clears flush_cnt.
- HALTED:
  - PC holds.
  - All inputs except reset_pi are ignored.
  - Only reset leaves this state.
- Outputs are decoded from state only, so they are glitch-free registered outputs:
  - fetch_valid_po = (state==RUN)
  - flush_po = (state==FLUSH)
  - halted_po = (state==HALTED)
- branch_count_po saturates at 16'hFFFF; a further accepted branch leaves it unchanged.
- Simultaneous halt_pi and is_branch_taken_pi: halt wins. The PC is not redirected and the count is unchanged.

## Timing
- Redirect latency is 1 edge:
  - is_branch_taken_pi is sampled high at edge N.
  - From edge N onward, pc_po=target and flush_po=1.
- flush_po is high for exactly FLUSH_DEPTH cycles.
- fetch_valid_po rises after those FLUSH_DEPTH cycles, with pc_po still equal to the target.
- Sequential advance: pc_po changes once per non-stalled RUN cycle.
- stall_pi acts in the same cycle: when high at edge N, pc_po is unchanged after edge N.
- halted_po rises 1 edge after halt_pi is sampled. From that edge fetch_valid_po=0 and flush_po=0.
- Reset asserted mid-FLUSH or mid-HALTED: all state returns to reset values immediately (asynchronous), not at the next edge. Deassertion is synchronous to clk_pi; the first increment happens at the first edge after deassertion.
- All inputs are assumed stable around the rising edge. There is no combinational path from input to output.

## Test plan
- Reset then 4 free-running cycles: pc_po steps 0,1,2,3,4; fetch_valid_po=1; flush_po=0; branch_count_po=0.
- At pc=5, pulse is_branch_taken_pi=1 with target 16'h0040 (FLUSH_DEPTH=2): next cycle pc_po=16'h0040, flush_po=1 for 2 cycles, fetch_valid_po=0. Then fetch_valid_po=1 and pc advances 0x40 to 0x41. branch_count_po=1.
- During FLUSH, assert is_branch_taken_pi with target 16'h0100: it is ignored. pc stays 0x40 and branch_count_po stays 1.
- stall_pi high for 3 cycles, with is_branch_taken_pi (target 0x20) raised in the middle stall cycle: pc holds, then redirects to 0x20 on the branch edge; the flush sequence follows.
- Load target 16'hFFFE and run through the flush: pc goes FFFE, FFFF, 0000. Also force 65535 accepted branches, then one more: branch_count_po stays 16'hFFFF.
- Assert halt_pi together with is_branch_taken_pi: halted_po=1 next cycle, pc unchanged, count unchanged, stall and branch inputs ignored. Assert reset_pi mid-halt: pc_po=RESET_PC and halted_po=0 without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// Fetch-control bundle between the pipeline and fetch_pc_unit.
// The pipeline drives stall/halt/branch; the unit returns PC and status.
interface fetch_pc_unit_if #(
  parameter int PC_WIDTH = 16
);
  logic                stall_pi;
  logic                halt_pi;
  logic                is_branch_taken_pi;
  logic [PC_WIDTH-1:0] branch_target_pi;
  logic [PC_WIDTH-1:0] pc_po;
  logic                fetch_valid_po;
  logic                flush_po;
  logic                halted_po;
  logic [15:0]         branch_count_po;

  modport master (
    output stall_pi, halt_pi, is_branch_taken_pi, branch_target_pi,
    input  pc_po, fetch_valid_po, flush_po, halted_po, branch_count_po
  );

  modport slave (
    input  stall_pi, halt_pi, is_branch_taken_pi, branch_target_pi,
    output pc_po, fetch_valid_po, flush_po, halted_po, branch_count_po
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter with taken-branch redirect, timed squash window, stall,
// sticky halt and a saturating count of accepted branches.
module fetch_pc_unit #(
  parameter int                  PC_WIDTH    = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  FLUSH_DEPTH = 2,
  parameter int                  COUNT_WIDTH = 16
) (
  input logic            clk_pi,
  input logic            reset_pi,
  fetch_pc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_HALTED
  } state_t;

  localparam logic [2:0]  FLUSH_INIT = 3'(FLUSH_DEPTH);
  // Saturation ceiling; COUNT_WIDTH below 16 only shortens the counter for debug builds.
  localparam logic [15:0] COUNT_MAX  = 16'((32'd1 << COUNT_WIDTH) - 32'd1);

  state_t              r_state;
  state_t              w_state_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [2:0]          r_flush_cnt;
  logic [2:0]          w_flush_cnt_next;
  logic [15:0]         r_branch_count;
  logic [15:0]         w_branch_count_next;

  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      r_state        <= S_RUN;
      r_pc           <= RESET_PC;
      r_flush_cnt    <= 3'd0;
      r_branch_count <= 16'd0;
    end else begin
      r_state        <= w_state_next;
      r_pc           <= w_pc_next;
      r_flush_cnt    <= w_flush_cnt_next;
      r_branch_count <= w_branch_count_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_pc_next           = r_pc;
    w_flush_cnt_next    = r_flush_cnt;
    w_branch_count_next = r_branch_count;
    case (r_state)
      S_RUN: begin
        if (bus.halt_pi) begin
          w_state_next = S_HALTED;
        end else if (bus.is_branch_taken_pi) begin
          w_state_next     = S_FLUSH;
          w_pc_next        = bus.branch_target_pi;
          w_flush_cnt_next = FLUSH_INIT;
          if (r_branch_count != COUNT_MAX) begin
            w_branch_count_next = r_branch_count + 16'd1;
          end
        end else if (!bus.stall_pi) begin
          w_pc_next = r_pc + PC_WIDTH'(1);
        end
      end
      // Branch and stall inputs here belong to squashed instructions.
      S_FLUSH: begin
        if (bus.halt_pi) begin
          w_state_next     = S_HALTED;
          w_flush_cnt_next = 3'd0;
        end else begin
          w_flush_cnt_next = r_flush_cnt - 3'd1;
          if (r_flush_cnt == 3'd1) begin
            w_state_next = S_RUN;
          end
        end
      end
      S_HALTED: begin
        w_state_next = S_HALTED;
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase
  end

  assign bus.pc_po           = r_pc;
  assign bus.fetch_valid_po  = (r_state == S_RUN);
  assign bus.flush_po        = (r_state == S_FLUSH);
  assign bus.halted_po       = (r_state == S_HALTED);
  assign bus.branch_count_po = r_branch_count;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized + directed scoreboard bench for fetch_pc_unit, plus a short-counter
// instance to reach branch-count saturation quickly.
module tb_fetch_pc_unit;

  localparam int          PCW    = 16;
  localparam logic [15:0] RST_PC = 16'h0000;
  localparam int          FD     = 2;

  typedef struct packed {
    logic [15:0] pc;
    logic        valid;
    logic        flush;
    logic        halted;
    logic [15:0] count;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic sat_rst;
  always #5 clk = ~clk;

  fetch_pc_unit_if #(.PC_WIDTH(PCW)) bus ();
  fetch_pc_unit_if #(.PC_WIDTH(PCW)) sat_bus ();

  fetch_pc_unit #(.PC_WIDTH(PCW), .RESET_PC(RST_PC), .FLUSH_DEPTH(FD), .COUNT_WIDTH(16)) dut (
    .clk_pi  (clk),
    .reset_pi(rst),
    .bus     (bus)
  );

  fetch_pc_unit #(.PC_WIDTH(PCW), .RESET_PC(16'h1234), .FLUSH_DEPTH(1), .COUNT_WIDTH(8)) dut_sat (
    .clk_pi  (clk),
    .reset_pi(sat_rst),
    .bus     (sat_bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;
  exp_t exp_q[$];

  // Reference model: remaining squash cycles, sticky halt, capped branch count.
  logic [15:0] m_pc;
  int          m_left;
  bit          m_halted;
  int          m_count;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_pc     = RST_PC;
    m_left   = 0;
    m_halted = 0;
    m_count  = 0;
  endtask

  // Called at a falling edge: drive inputs, predict the result of the next
  // rising edge, then wait for the following falling edge.
  task automatic step(input logic st, input logic hl, input logic br, input logic [15:0] tg);
    exp_t e;
    bus.stall_pi           = st;
    bus.halt_pi            = hl;
    bus.is_branch_taken_pi = br;
    bus.branch_target_pi   = tg;
    if (m_halted) begin
      // frozen until reset
    end else if (hl) begin
      m_halted = 1;
      m_left   = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
    end else if (br) begin
      m_pc    = tg;
      m_left  = FD;
      m_count = (m_count < 65535) ? m_count + 1 : 65535;
    end else if (!st) begin
      m_pc = m_pc + 16'd1;
    end
    e.pc     = m_pc;
    e.valid  = !m_halted && (m_left == 0);
    e.flush  = !m_halted && (m_left > 0);
    e.halted = m_halted;
    e.count  = 16'(m_count);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one comparison per rising edge that has a pending expectation.
  always @(posedge clk) begin
    exp_t e;
    exp_t got;
    #1;
    if (exp_q.size() > 0) begin
      e          = exp_q.pop_front();
      got.pc     = bus.pc_po;
      got.valid  = bus.fetch_valid_po;
      got.flush  = bus.flush_po;
      got.halted = bus.halted_po;
      got.count  = bus.branch_count_po;
      txn++;
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL txn %0d: got pc=%h v=%b f=%b h=%b cnt=%0d expected pc=%h v=%b f=%b h=%b cnt=%0d",
                 txn, got.pc, got.valid, got.flush, got.halted, got.count,
                 e.pc, e.valid, e.flush, e.halted, e.count);
      end else begin
        $display("txn %0d pc=%h v=%b f=%b h=%b cnt=%0d", txn, got.pc, got.valid, got.flush,
                 got.halted, got.count);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                        = 1'b1;
    sat_rst                    = 1'b1;
    bus.stall_pi               = 1'b0;
    bus.halt_pi                = 1'b0;
    bus.is_branch_taken_pi     = 1'b0;
    bus.branch_target_pi       = 16'h0000;
    sat_bus.stall_pi           = 1'b0;
    sat_bus.halt_pi            = 1'b0;
    sat_bus.is_branch_taken_pi = 1'b1;
    sat_bus.branch_target_pi   = 16'h0777;
    model_reset();

    #1;
    chk("reset pc", bus.pc_po, RST_PC);
    chk("reset valid", bus.fetch_valid_po, 1);
    chk("reset flush", bus.flush_po, 0);
    chk("reset halted", bus.halted_po, 0);
    chk("reset count", bus.branch_count_po, 0);
    chk("sat reset pc", sat_bus.pc_po, 16'h1234);

    // Short counter with the branch held high: accepted on every other edge.
    @(negedge clk);
    sat_rst = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("sat count after 11 edges", sat_bus.branch_count_po, 6);
    chk("sat pc target", sat_bus.pc_po, 16'h0777);
    chk("sat flush after accept", sat_bus.flush_po, 1);
    repeat (600) @(posedge clk);
    #1;
    chk("sat count saturated", sat_bus.branch_count_po, 255);
    chk("sat still accepting", sat_bus.flush_po, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("sat count held", sat_bus.branch_count_po, 255);

    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Free run 1..5, then redirect to 0x40 with a squashed branch inside FLUSH.
    repeat (5) step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 16'h0040);
    step(1'b0, 1'b0, 1'b1, 16'h0100);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0000);

    // Stall window with a branch in the middle stall cycle.
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'h0020);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (4) step(1'b0, 1'b0, 1'b0, 16'h0000);

    // PC wrap through FFFF.
    step(1'b0, 1'b0, 1'b1, 16'hFFFE);
    repeat (5) step(1'b0, 1'b0, 1'b0, 16'h0000);

    for (int i = 0; i < 1200; i++) begin
      step($urandom_range(0, 3) == 0, 1'b0, $urandom_range(0, 4) == 0, 16'($urandom));
    end

    // Halt together with a branch, then inputs that must be ignored.
    step(1'b0, 1'b1, 1'b1, 16'h0055);
    for (int i = 0; i < 6; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
    end

    // Asynchronous reset while halted, checked before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("async reset pc", bus.pc_po, RST_PC);
    chk("async reset halted", bus.halted_po, 0);
    chk("async reset valid", bus.fetch_valid_po, 1);
    chk("async reset count", bus.branch_count_po, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 3) == 0, 16'($urandom));
    end

    chk("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
